// File: rtl/mdu_iter_if.sv
// ============================================================================
// Module  : mdu_iter_if
// Brief   : Handshake/data bundle between the control path and the iterative MDU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wr_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wr_data,
        output busy, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/mdu_iter.sv
// ============================================================================
// Module  : mdu_iter
// Brief   : Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO pair.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    mdu_iter_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC   = 3'd1,
        ST_FIX    = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_count;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_addend;
    logic [WIDTH-1:0]   r_a_orig;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_signed;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_b_zero;
    logic               w_busy;
    logic               w_accept;
    logic               w_last;

    assign w_last = (r_count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // COMMIT sits between FIX and DONE so that the result lands one edge after the fix-up.
    always_comb begin
        w_next   = r_state;
        w_busy   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = bus.start;
                if (bus.start) w_next = ST_CALC;
            end
            ST_CALC: begin
                w_busy = 1'b1;
                if (w_last) w_next = ST_FIX;
            end
            ST_FIX: begin
                w_busy = 1'b1;
                w_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_busy = 1'b1;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                w_accept = bus.start;
                w_next   = bus.start ? ST_CALC : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand conditioning at capture time.
    logic             w_op_signed;
    logic             w_op_div;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign w_op_signed = ~bus.op[0];
    assign w_op_div    = bus.op[1];
    assign w_abs_a     = (w_op_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_abs_b     = (w_op_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Shift-add step: upper half accumulates the multiplicand, multiplier drains from the bottom.
    logic [WIDTH:0]     w_msum;
    logic [2*WIDTH-1:0] w_mstep;

    assign w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_addend};
    assign w_mstep = r_acc[0] ? {w_msum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

    // Restoring step: remainder in the upper half, dividend/quotient in the lower half.
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_dstep;

    assign w_trial = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff  = w_trial - {1'b0, r_addend};
    assign w_dstep = w_diff[WIDTH] ? {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    // Sign fix-up and divide-by-zero override.
    logic               w_neg_res;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [2*WIDTH-1:0] w_fix;

    assign w_neg_res  = r_signed && (r_sign_a ^ r_sign_b);
    assign w_prod_fix = w_neg_res ? -r_acc : r_acc;
    assign w_quot_fix = w_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = (r_signed && r_sign_a) ? -r_acc[2*WIDTH-1:WIDTH]
                                               : r_acc[2*WIDTH-1:WIDTH];
    assign w_fix      = !r_is_div ? w_prod_fix
                      : r_b_zero  ? {r_a_orig, {WIDTH{1'b1}}}
                      :             {w_rem_fix, w_quot_fix};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_addend <= '0;
            r_a_orig <= '0;
            r_is_div <= 1'b0;
            r_signed <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_b_zero <= 1'b0;
        end else if (w_accept) begin
            r_count  <= '0;
            r_acc    <= {{WIDTH{1'b0}}, (w_op_div ? w_abs_a : w_abs_b)};
            r_addend <= w_op_div ? w_abs_b : w_abs_a;
            r_a_orig <= bus.a;
            r_is_div <= w_op_div;
            r_signed <= w_op_signed;
            r_sign_a <= bus.a[WIDTH-1];
            r_sign_b <= bus.b[WIDTH-1];
            r_b_zero <= (bus.b == '0);
        end else if (r_state == ST_CALC) begin
            r_acc   <= r_is_div ? w_dstep : w_mstep;
            r_count <= r_count + CNT_W'(1);
        end else if (r_state == ST_FIX) begin
            r_acc <= w_fix;
        end
    end

    // A write in the DONE cycle lands after the result, so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == ST_COMMIT) begin
            r_hi <= r_acc[2*WIDTH-1:WIDTH];
            r_lo <= r_acc[WIDTH-1:0];
        end else if (!w_busy) begin
            if (bus.hi_we) r_hi <= bus.wr_data;
            if (bus.lo_we) r_lo <= bus.wr_data;
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = (r_state == ST_DONE);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

`default_nettype wire
